// File: rtl/rtc_set_ctrl.sv
// rtc_set_ctrl: hh:mm:ss timekeeping core with in-place field editing via mode/inc/dec buttons.
// Define RTC_SET_CTRL_AUTO_REPEAT_EN to enable auto-repeat of a held inc/dec button while editing.
module rtc_set_ctrl #(
  parameter int unsigned TICK_CYCLES   = 100_000_000,
  parameter int unsigned BLINK_CYCLES  = 25_000_000,
  parameter int unsigned HOURS_MOD     = 24,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 10_000_000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       mode_i,
  output logic [5:0] seconds_o,
  output logic [5:0] minutes_o,
  output logic [4:0] hours_o,
  output logic [1:0] field_sel_o,
  output logic       editing_o,
  output logic       blink_o,
  output logic       tick_o
);

  localparam int unsigned PRESC_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [5:0]         SEXA_MAX   = 6'd59;
  localparam logic [5:0]         HOUR_MAX   = 6'(HOURS_MOD - 1);

  if (HOURS_MOD != 12 && HOURS_MOD != 24) begin : g_bad_hours_mod
    $error("rtc_set_ctrl: HOURS_MOD must be 12 or 24");
  end
  if (TICK_CYCLES == 0 || BLINK_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)
  begin : g_bad_cycles
    $error("rtc_set_ctrl: cycle parameters must be non-zero");
  end

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } state_e;

  state_e               state_q;
  state_e               state_nxt;
  logic [PRESC_W-1:0]   presc_q;
  logic [BLINK_W-1:0]   blink_cnt_q;
  logic                 blink_q;
  logic                 tick_q;
  logic                 editing_q;
  logic [1:0]           field_sel_q;
  logic [5:0]           sec_q, sec_d;
  logic [5:0]           min_q, min_d;
  logic [4:0]           hr_q, hr_d;
  logic                 inc_prev_q, dec_prev_q, mode_prev_q;

  logic inc_press, dec_press, mode_press;
  logic in_set, run_tick;
  logic step_up, step_dn;
  logic rep_up, rep_dn;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v == top) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] top);
    return (v == 6'd0) ? top : v - 6'd1;
  endfunction

  assign inc_press  = inc_i  & ~inc_prev_q;
  assign dec_press  = dec_i  & ~dec_prev_q;
  assign mode_press = mode_i & ~mode_prev_q;

  assign in_set   = (state_q != RUN);
  assign run_tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // A mode press always wins over a simultaneous inc/dec; inc+dec together cancel.
  assign step_up = in_set && !mode_press && ((inc_press && !dec_press) || rep_up);
  assign step_dn = in_set && !mode_press && ((dec_press && !inc_press) || rep_dn);

`ifdef RTC_SET_CTRL_AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W  = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_phase_q, rep_phase_d;
  logic              rep_armed_q, rep_armed_d;
  logic              rep_fire;

  // Hold counter runs only while exactly one button stays down after its own press in a SET state.
  always_comb begin
    hold_d      = hold_q;
    rep_phase_d = rep_phase_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (!in_set || mode_press || inc_press || dec_press || (inc_i == dec_i)) begin
      hold_d      = '0;
      rep_phase_d = 1'b0;
      rep_armed_d = in_set && !mode_press && (inc_press ^ dec_press);
    end else if (rep_armed_q) begin
      if (hold_q == (rep_phase_q ? PERIOD_LAST : DELAY_LAST)) begin
        hold_d      = '0;
        rep_phase_d = 1'b1;
        rep_fire    = 1'b1;
      end else begin
        hold_d = hold_q + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q      <= '0;
      rep_phase_q <= 1'b0;
      rep_armed_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      rep_phase_q <= rep_phase_d;
      rep_armed_q <= rep_armed_d;
    end
  end

  assign rep_up = rep_fire & inc_i;
  assign rep_dn = rep_fire & dec_i;
`else
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  always_comb begin
    unique case (state_q)
      RUN:     state_nxt = SET_HH;
      SET_HH:  state_nxt = SET_MM;
      SET_MM:  state_nxt = SET_SS;
      default: state_nxt = RUN;
    endcase
  end

  // Next time value: carry chain on a tick, single-field wrap on an edit step.
  always_comb begin
    sec_d = sec_q;
    min_d = min_q;
    hr_d  = hr_q;
    if (run_tick) begin
      sec_d = wrap_inc(sec_q, SEXA_MAX);
      if (sec_q == SEXA_MAX) begin
        min_d = wrap_inc(min_q, SEXA_MAX);
        if (min_q == SEXA_MAX) begin
          hr_d = 5'(wrap_inc({1'b0, hr_q}, HOUR_MAX));
        end
      end
    end else if (step_up || step_dn) begin
      unique case (state_q)
        SET_HH:  hr_d  = step_up ? 5'(wrap_inc({1'b0, hr_q}, HOUR_MAX))
                                 : 5'(wrap_dec({1'b0, hr_q}, HOUR_MAX));
        SET_MM:  min_d = step_up ? wrap_inc(min_q, SEXA_MAX) : wrap_dec(min_q, SEXA_MAX);
        SET_SS:  sec_d = step_up ? wrap_inc(sec_q, SEXA_MAX) : wrap_dec(sec_q, SEXA_MAX);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= RUN;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      tick_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_sel_q <= 2'd0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hr_q        <= 5'd0;
      inc_prev_q  <= 1'b1;
      dec_prev_q  <= 1'b1;
      mode_prev_q <= 1'b1;
    end else begin
      inc_prev_q  <= inc_i;
      dec_prev_q  <= dec_i;
      mode_prev_q <= mode_i;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      tick_q      <= run_tick;

      if (mode_press) begin
        state_q     <= state_nxt;
        field_sel_q <= 2'(state_nxt);
        editing_q   <= (state_nxt != RUN);
        presc_q     <= '0;
        blink_cnt_q <= '0;
        blink_q     <= (state_nxt != RUN);
      end else if (state_q == RUN) begin
        presc_q <= run_tick ? '0 : presc_q + PRESC_W'(1);
      end else begin
        presc_q <= '0;
        // Restart the blink phase on each step so the new value is shown immediately.
        if (step_up || step_dn) begin
          blink_cnt_q <= '0;
          blink_q     <= 1'b1;
        end else if (blink_cnt_q == BLINK_LAST) begin
          blink_cnt_q <= '0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
      end
    end
  end

  assign seconds_o   = sec_q;
  assign minutes_o   = min_q;
  assign hours_o     = hr_q;
  assign field_sel_o = field_sel_q;
  assign editing_o   = editing_q;
  assign blink_o     = blink_q;
  assign tick_o      = tick_q;

endmodule
